// File: rtl/stream_demux_1to2_16bit_if.sv
// Handshake bundle for the 1-to-2 stream demultiplexer: input stream, two output
// streams, routing controls and the registered routing status.
interface stream_demux_1to2_16bit_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 4
);
  logic              mode;
  logic              sel;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out0_data;
  logic              out0_valid;
  logic              out0_ready;
  logic [DATA_W-1:0] out1_data;
  logic              out1_valid;
  logic              out1_ready;
  logic              cur_port;
  logic [CNT_W-1:0]  beat_cnt;

  modport master (
    output mode, sel, in_data, in_valid, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out1_data, out1_valid,
    input  cur_port, beat_cnt
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out1_data, out1_valid,
    output cur_port, beat_cnt
  );
endinterface

// File: rtl/stream_demux_1to2_16bit.sv
// 1-to-2 stream demultiplexer with a one-entry register per output port; routes by
// sel (fixed mode) or alternates whole BURST_LEN-beat bursts between ports.
module stream_demux_1to2_16bit #(
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 9,
  parameter int CNT_W     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  stream_demux_1to2_16bit_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  logic              cur_port_q;
  logic              cur_port_d;
  logic [CNT_W-1:0]  beat_cnt_q;
  logic [CNT_W-1:0]  beat_cnt_d;
  logic [1:0]        out_ready;
  logic [1:0]        out_valid;
  logic [DATA_W-1:0] out_data [2];
  logic              in_ready;
  logic              accept;

  assign out_ready = {bus.out1_ready, bus.out0_ready};

  // Only the selected port gates the input, so a stalled target blocks even when
  // the other port is empty; in_valid never feeds back into in_ready.
  assign in_ready = ~out_valid[cur_port_q] | out_ready[cur_port_q];
  assign accept   = bus.in_valid & in_ready;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      localparam logic PORT = 1'(gi);

      logic              wr;
      logic              drain;
      logic              valid_q;
      logic              valid_d;
      logic [DATA_W-1:0] data_q;
      logic [DATA_W-1:0] data_d;

      assign wr    = accept & (cur_port_q == PORT);
      assign drain = valid_q & out_ready[gi];

      // A write in the same cycle as a drain refills the slot, sustaining 1 beat/cycle.
      always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (wr) begin
          valid_d = 1'b1;
          data_d  = bus.in_data;
        end else if (drain) begin
          valid_d = 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= 1'b0;
          data_q  <= '0;
        end else begin
          valid_q <= valid_d;
          data_q  <= data_d;
        end
      end

      assign out_valid[gi] = valid_q;
      assign out_data[gi]  = data_q;
    end
  endgenerate

  always_comb begin
    cur_port_d = cur_port_q;
    beat_cnt_d = beat_cnt_q;
    if (!bus.mode) begin
      cur_port_d = bus.sel;
      beat_cnt_d = '0;
    end else if (accept) begin
      // Last beat of a burst wraps the counter and hands the stream to the other port.
      if (beat_cnt_q == LAST_BEAT) begin
        beat_cnt_d = '0;
        cur_port_d = ~cur_port_q;
      end else begin
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_port_q <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      cur_port_q <= cur_port_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out0_valid = out_valid[0];
  assign bus.out0_data  = out_data[0];
  assign bus.out1_valid = out_valid[1];
  assign bus.out1_data  = out_data[1];
  assign bus.cur_port   = cur_port_q;
  assign bus.beat_cnt   = beat_cnt_q;

endmodule

// File: tb/tb_stream_demux_1to2_16bit.sv
// Bench for stream_demux_1to2_16bit: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_stream_demux_1to2_16bit;
  localparam int DATA_W    = 16;
  localparam int BURST_LEN = 9;
  localparam int CNT_W     = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_demux_1to2_16bit_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  stream_demux_1to2_16bit #(
    .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit verbose  = 1'b1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: per-port queues of beats not yet consumed, routing computed
  // from the number of beats accepted since alternating mode was entered.
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] last0   = '0;
  logic [15:0] last1   = '0;
  logic        m_cur   = 1'b0;
  logic        m_start = 1'b0;
  int          m_cnt   = 0;
  int          n_acc   = 0;
  bit          exp_rdy;
  bit          acc;
  logic        dest;

  always @(posedge clk) begin
    #2;
    chk("out0_valid", bus.out0_valid, (q0.size() != 0));
    chk("out1_valid", bus.out1_valid, (q1.size() != 0));
    chk("out0_data", bus.out0_data, (q0.size() != 0) ? q0[0] : last0);
    chk("out1_data", bus.out1_data, (q1.size() != 0) ? q1[0] : last1);
    chk("cur_port", bus.cur_port, m_cur);
    chk("beat_cnt", bus.beat_cnt, m_cnt);
    exp_rdy = m_cur ? (q1.size() == 0 || bus.out1_ready) : (q0.size() == 0 || bus.out0_ready);
    chk("in_ready", bus.in_ready, exp_rdy);

    if (rst) begin
      q0.delete();
      q1.delete();
      last0 = '0;
      last1 = '0;
      m_cur = 1'b0;
      m_start = 1'b0;
      m_cnt = 0;
      n_acc = 0;
    end else begin
      acc  = bus.in_valid && exp_rdy;
      dest = m_cur;
      if (q0.size() != 0 && bus.out0_ready) void'(q0.pop_front());
      if (q1.size() != 0 && bus.out1_ready) void'(q1.pop_front());
      if (acc) begin
        if (dest) begin
          q1.push_back(bus.in_data);
          last1 = bus.in_data;
        end else begin
          q0.push_back(bus.in_data);
          last0 = bus.in_data;
        end
      end
      if (!bus.mode) begin
        m_cur = bus.sel;
        m_start = bus.sel;
        m_cnt = 0;
        n_acc = 0;
      end else if (acc) begin
        n_acc++;
        m_cnt = n_acc % BURST_LEN;
        m_cur = m_start ^ 1'((n_acc / BURST_LEN) % 2);
      end
      if (verbose && acc)
        $display("beat %04h -> out%0d  cnt_next=%0d port_next=%0d", bus.in_data, dest, m_cnt, m_cur);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.mode = 1'b0;
    bus.sel = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_out0_valid", bus.out0_valid, 1'b0);
    chk("rst_out1_valid", bus.out1_valid, 1'b0);
    chk("rst_beat_cnt", bus.beat_cnt, 0);
    chk("rst_cur_port", bus.cur_port, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);

    // Fixed mode to out1, four back-to-back beats
    tick();
    bus.mode = 1'b0;
    bus.sel = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      bus.in_valid = (k <= 4);
      bus.in_data = 16'(k);
      #1;
      if (k == 1) chk("fix_cur_port", bus.cur_port, 1'b1);
      else begin
        chk("fix_out1_data", bus.out1_data, 16'(k - 1));
        chk("fix_out1_valid", bus.out1_valid, 1'b1);
        chk("fix_out0_valid", bus.out0_valid, 1'b0);
      end
    end

    // Alternating mode, 18 beats: two full bursts
    tick();
    bus.in_valid = 1'b0;
    bus.sel = 1'b0;
    tick();
    bus.mode = 1'b1;
    for (int i = 0; i <= 18; i++) begin
      tick();
      bus.in_valid = (i < 18);
      bus.in_data = 16'(16'h0100 + i);
      #1;
      if (i > 0) begin
        if (i - 1 < 9) begin
          chk("alt_out0_data", bus.out0_data, 16'(16'h0100 + i - 1));
          chk("alt_out0_valid", bus.out0_valid, 1'b1);
        end else begin
          chk("alt_out1_data", bus.out1_data, 16'(16'h0100 + i - 1));
        end
        chk("alt_beat_cnt", bus.beat_cnt, i % 9);
        chk("alt_cur_port", bus.cur_port, (i - 1 < 8) ? 1'b0 : (i - 1 < 17) ? 1'b1 : 1'b0);
      end
    end

    // Stall out0 after two beats
    tick();
    bus.in_valid = 1'b1;
    bus.in_data = 16'h0100;
    tick();
    bus.in_data = 16'h0101;
    tick();
    bus.in_data = 16'h0102;
    bus.out0_ready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      if (s > 0) tick();
      #1;
      chk("stall_out0_data", bus.out0_data, 16'h0101);
      chk("stall_in_ready", bus.in_ready, 1'b0);
      chk("stall_beat_cnt", bus.beat_cnt, 2);
    end
    tick();
    bus.out0_ready = 1'b1;
    tick();
    bus.in_data = 16'h0103;
    #1;
    chk("resume_out0_data", bus.out0_data, 16'h0102);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("resume_out0_data2", bus.out0_data, 16'h0103);

    // Reset mid-burst with out1 full
    tick();
    bus.mode = 1'b0;
    bus.sel = 1'b1;
    tick();
    bus.mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.in_valid = 1'b1;
      bus.in_data = 16'(16'h0200 + i);
    end
    tick();
    bus.in_valid = 1'b0;
    bus.out1_ready = 1'b0;
    #1;
    chk("pre_rst_beat_cnt", bus.beat_cnt, 5);
    chk("pre_rst_out1_valid", bus.out1_valid, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_out0_valid", bus.out0_valid, 1'b0);
    chk("mid_rst_out1_valid", bus.out1_valid, 1'b0);
    chk("mid_rst_beat_cnt", bus.beat_cnt, 0);
    chk("mid_rst_cur_port", bus.cur_port, 1'b0);
    chk("mid_rst_out1_data", bus.out1_data, 16'h0000);

    // Mode 1 -> 0 at beat_cnt 3 with sel=1
    tick();
    bus.out1_ready = 1'b1;
    bus.mode = 1'b0;
    bus.sel = 1'b1;
    tick();
    bus.mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.in_valid = 1'b1;
      bus.in_data = 16'(16'h0300 + i);
    end
    tick();
    bus.in_valid = 1'b0;
    bus.mode = 1'b0;
    #1;
    chk("m10_beat_cnt_before", bus.beat_cnt, 3);
    tick();
    bus.in_valid = 1'b1;
    bus.in_data = 16'h03AA;
    #1;
    chk("m10_beat_cnt", bus.beat_cnt, 0);
    chk("m10_cur_port", bus.cur_port, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("m10_out1_data", bus.out1_data, 16'h03AA);
    chk("m10_out1_valid", bus.out1_valid, 1'b1);

    // Randomized traffic
    verbose = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 59) == 0) bus.mode = ~bus.mode;
      if ($urandom_range(0, 4) == 0) bus.sel = 1'($urandom);
      bus.in_valid = ($urandom_range(0, 9) < 7);
      bus.in_data = 16'($urandom);
      bus.out0_ready = ($urandom_range(0, 9) < 7);
      bus.out1_ready = ($urandom_range(0, 9) < 6);
    end
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/stream_demux_1to2_16bit.md
STREAM_DEMUX_1TO2_16BIT -- requirements
Module: stream_demux_1to2_16bit

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DATA_W, 16, data width of input and both outputs
  BURST_LEN, 9, beats per burst in alternating mode (one 3x3 kernel window)
  CNT_W, 4, beat counter width; SHALL satisfy 2^CNT_W >= BURST_LEN
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk, in, 1, single clock; all state updates on rising edge
  rst, in, 1, synchronous active-high reset
  mode, in, 1, 0 = fixed routing by sel; 1 = alternating bursts
  sel, in, 1, target port in fixed mode (0 -> out0, 1 -> out1)
  in_data, in, DATA_W, input beat
  in_valid, in, 1, input beat present
  in_ready, out, 1, block accepts input this cycle
  out0_data, out, DATA_W, port 0 beat
  out0_valid, out, 1, port 0 beat present
  out0_ready, in, 1, port 0 consumer accepts
  out1_data, out, DATA_W, port 1 beat
  out1_valid, out, 1, port 1 beat present
  out1_ready, in, 1, port 1 consumer accepts
  cur_port, out, 1, port receiving the next accepted beat (registered)
  beat_cnt, out, CNT_W, beats accepted in current burst (registered)
REQ-003 The block SHALL use one clock (clk) and a synchronous, active-high reset (rst); no other clock or asynchronous reset.

Function
REQ-004 Each output port SHALL own a one-entry register (data + valid flag).
REQ-005 in_ready SHALL equal (!outN_valid | outN_ready) with N = cur_port; it SHALL be combinational from those signals only, never from in_valid.
REQ-006 Accept = in_valid & in_ready; on accept, in_data SHALL be written into port cur_port register and its valid set; beat visible on outN_data the next cycle (latency 1).
REQ-007 A port's valid SHALL clear when outN_valid & outN_ready and no write to that port occurs the same cycle; simultaneous drain and write SHALL keep valid=1 with new data (1 beat/cycle sustained).
REQ-008 While outN_valid=1 and outN_ready=0, outN_data SHALL hold stable.
REQ-009 The non-selected port SHALL never be written; it drains independently.
REQ-010 No beat SHALL be dropped, duplicated or reordered within a port.
REQ-011 Fixed mode (mode=0): cur_port SHALL load sel every cycle (1-cycle lag from sel); beat_cnt SHALL be held at 0.
REQ-012 Alternating mode (mode=1): on each accept, beat_cnt SHALL increment; on an accept with beat_cnt = BURST_LEN-1, beat_cnt SHALL wrap to 0 and cur_port SHALL toggle in the same edge.
REQ-013 Cycles without accept SHALL leave beat_cnt and cur_port unchanged in mode 1.
REQ-014 Mode 1 -> 0 transition SHALL clear beat_cnt on the next edge; mode 0 -> 1 SHALL start counting from 0 at the cur_port value then held.
REQ-015 A stalled selected port SHALL stall input (in_ready=0) even if the other port is empty.

Reset
REQ-016 On rst=1 at a rising edge: out0_valid, out1_valid = 0; out0_data, out1_data = 0; beat_cnt = 0; cur_port = 0.
REQ-017 rst SHALL take priority over accept and drain in the same cycle; buffered beats SHALL be discarded.
REQ-018 in_ready SHALL be 1 in the first cycle after reset release (both ports empty).

Verification
REQ-019 Fixed mode, sel=1, both ready, send 0x0001..0x0004 back-to-back -> out1 shows 0x0001..0x0004 on consecutive cycles, latency 1; out0_valid stays 0.
REQ-020 Mode 1, both ready, send 18 beats 0x0100..0x0111 -> out0 gets 0x0100..0x0108, out1 gets 0x0109..0x0111; beat_cnt wraps 8->0 twice; cur_port ends 0.
REQ-021 Mode 1, out0_ready=0 after 2 beats accepted -> out0_data holds 0x0101, in_ready=0 while out0_valid=1; releasing out0_ready resumes with no loss.
REQ-022 Simultaneous drain and write on out0 with ready held 1 -> valid stays 1, data updates every cycle, 1 beat/cycle throughput.
REQ-023 rst asserted mid-burst at beat_cnt=5 with out1 full -> next cycle all valids 0, beat_cnt 0, cur_port 0, data 0.
REQ-024 Mode toggled 1->0 at beat_cnt=3 with sel=1 -> beat_cnt 0 next edge, cur_port 1, subsequent beats route to out1.
